timer_multi: RTL and testbench

TIMER_MULTI -- requirements
Module: timer_multi

---
 rtl/timer_pkg.sv | 44 ++++
 rtl/timer_channel.sv | 119 +++++++++++
 rtl/timer_multi.sv | 98 +++++++++
 tb/tb_timer_multi.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_pkg : register map and CTRL bit layout for timer_multi         |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package timer_pkg;

  localparam int unsigned c_addr_w = 32;
  localparam int unsigned c_data_w = 32;

  localparam logic [7:0] c_ch_stride  = 8'h10;
  localparam logic [7:0] c_irq_status = 8'h80;

  localparam logic [3:0] c_off_ctrl  = 4'h0;
  localparam logic [3:0] c_off_count = 4'h4;
  localparam logic [3:0] c_off_cmp   = 4'h8;
  localparam logic [3:0] c_off_presc = 4'hC;

  localparam int unsigned c_ctrl_en   = 0;
  localparam int unsigned c_ctrl_ie   = 1;
  localparam int unsigned c_ctrl_pend = 2;
  localparam int unsigned c_ctrl_mode = 3;

  typedef enum logic [2:0] {
    REG_CTRL  = 3'd0,
    REG_COUNT = 3'd1,
    REG_CMP   = 3'd2,
    REG_PRESC = 3'd3,
    REG_NONE  = 3'd4
  } reg_sel_e;

  // Offsets inside a channel block; anything not word-exact is unmapped.
  function automatic reg_sel_e decode_off(input logic [3:0] off);
    case (off)
      c_off_ctrl:  return REG_CTRL;
      c_off_count: return REG_COUNT;
      c_off_cmp:   return REG_CMP;
      c_off_presc: return REG_PRESC;
      default:     return REG_NONE;
    endcase
  endfunction

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_channel : one prescaled compare timer with W1C pending flag    |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                i_ctrl_we,
  input  logic                i_cmp_we,
  input  logic                i_presc_we,
  input  logic [c_data_w-1:0] i_wdata,
  output logic [3:0]          o_ctrl,
  output logic [CNT_W-1:0]    o_count,
  output logic [CNT_W-1:0]    o_cmp,
  output logic [PRESC_W-1:0]  o_presc,
  output logic                o_pend,
  output logic                o_irq
);

  logic               r_en;
  logic               r_ie;
  logic               r_pend;
  logic               r_mode;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_cmp;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] r_psc;

  logic w_tick;
  logic w_match;
  logic w_en_nxt;
  logic w_pend_nxt;
  logic w_run;
  logic w_unused_wdata;

  // >= keeps a lowered PRESC from letting the prescaler run to wrap-around.
  assign w_tick  = r_en && (r_psc >= r_presc);
  assign w_match = w_tick && (r_count >= r_cmp);

  always_comb begin
    w_en_nxt = i_ctrl_we ? i_wdata[c_ctrl_en] : r_en;
    if (w_match && !r_mode) begin
      w_en_nxt = 1'b0;
    end
    w_pend_nxt = r_pend;
    if (i_ctrl_we && i_wdata[c_ctrl_pend]) begin
      w_pend_nxt = 1'b0;
    end
    if (w_match) begin
      w_pend_nxt = 1'b1;
    end
  end

  // Counting only proceeds while enabled before and after the edge, so a
  // fresh enable always starts from zero and a disable clears immediately.
  assign w_run = r_en && w_en_nxt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_en    <= 1'b0;
      r_ie    <= 1'b0;
      r_pend  <= 1'b0;
      r_mode  <= 1'b0;
      r_cmp   <= '0;
      r_presc <= '0;
    end else begin
      r_en   <= w_en_nxt;
      r_pend <= w_pend_nxt;
      if (i_ctrl_we) begin
        r_ie   <= i_wdata[c_ctrl_ie];
        r_mode <= i_wdata[c_ctrl_mode];
      end
      if (i_cmp_we) begin
        r_cmp <= i_wdata[CNT_W-1:0];
      end
      if (i_presc_we) begin
        r_presc <= i_wdata[PRESC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_psc   <= '0;
      r_count <= '0;
    end else if (!w_run) begin
      r_psc   <= '0;
      r_count <= '0;
    end else begin
      if (w_tick) begin
        r_psc <= '0;
      end else begin
        r_psc <= r_psc + 1'b1;
      end
      if (w_match) begin
        r_count <= '0;
      end else if (w_tick) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign w_unused_wdata = ^i_wdata;

  assign o_ctrl  = {r_mode, r_pend, r_ie, r_en};
  assign o_count = r_count;
  assign o_cmp   = r_cmp;
  assign o_presc = r_presc;
  assign o_pend  = r_pend;
  assign o_irq   = r_pend & r_ie;

endmodule : timer_channel
`default_nettype wire

// File: rtl/timer_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_multi : NUM_CH independent timers behind a small register bus  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module timer_multi
  import timer_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wen_i,
  input  logic [c_addr_w-1:0] waddr_i,
  input  logic [c_data_w-1:0] wdata_i,
  input  logic [c_addr_w-1:0] raddr_i,
  output logic [c_data_w-1:0] rdata_o,
  output logic [NUM_CH-1:0]   timer_irq_o,
  output logic                timer_int_flag_o
);

  logic [7:0]                          r_raddr;
  logic [NUM_CH-1:0]                   w_pend;
  logic [NUM_CH-1:0][3:0]              w_ctrl;
  logic [NUM_CH-1:0][CNT_W-1:0]        w_count;
  logic [NUM_CH-1:0][CNT_W-1:0]        w_cmp;
  logic [NUM_CH-1:0][PRESC_W-1:0]      w_presc;
  logic [c_data_w-1:0]                 w_rdata;
  reg_sel_e                            w_wsel;
  reg_sel_e                            w_rsel;
  logic                                w_unused_addr;

  assign w_wsel = decode_off(waddr_i[3:0]);
  assign w_rsel = decode_off(r_raddr[3:0]);

  // Channel indices at or above NUM_CH simply match no generated block.
  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      localparam logic [7:0] c_base = c_ch_stride * 8'(g);
      logic w_hit;

      assign w_hit = wen_i && (waddr_i[7:4] == c_base[7:4]);

      timer_channel #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
      ) u_channel (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_ctrl_we  (w_hit && (w_wsel == REG_CTRL)),
        .i_cmp_we   (w_hit && (w_wsel == REG_CMP)),
        .i_presc_we (w_hit && (w_wsel == REG_PRESC)),
        .i_wdata    (wdata_i),
        .o_ctrl     (w_ctrl[g]),
        .o_count    (w_count[g]),
        .o_cmp      (w_cmp[g]),
        .o_presc    (w_presc[g]),
        .o_pend     (w_pend[g]),
        .o_irq      (timer_irq_o[g])
      );
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_raddr <= '0;
    end else begin
      r_raddr <= raddr_i[7:0];
    end
  end

  always_comb begin
    w_rdata = '0;
    if (r_raddr == c_irq_status) begin
      w_rdata[NUM_CH-1:0] = w_pend;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (r_raddr[7:4] == c[3:0]) begin
          case (w_rsel)
            REG_CTRL:  w_rdata[3:0]         = w_ctrl[c];
            REG_COUNT: w_rdata[CNT_W-1:0]   = w_count[c];
            REG_CMP:   w_rdata[CNT_W-1:0]   = w_cmp[c];
            REG_PRESC: w_rdata[PRESC_W-1:0] = w_presc[c];
            default:   w_rdata              = '0;
          endcase
        end
      end
    end
  end

  assign w_unused_addr    = ^{waddr_i[c_addr_w-1:8], raddr_i[c_addr_w-1:8]};
  assign rdata_o          = w_rdata;
  assign timer_int_flag_o = |timer_irq_o;

endmodule : timer_multi
`default_nettype wire

// File: tb/tb_timer_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_timer_multi : directed self-checking bench for timer_multi        |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_timer_multi;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wen_i;
  logic [31:0] waddr_i;
  logic [31:0] wdata_i;
  logic [31:0] raddr_i;
  logic [31:0] rdata_o;
  logic [3:0]  timer_irq_o;
  logic        timer_int_flag_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] bad_addr [8] = '{32'h40, 32'h44, 32'h48, 32'h4C,
                                32'h01, 32'h04, 32'h80, 32'hC0};

  always #5 clk_i = ~clk_i;

  timer_multi #(
    .NUM_CH  (4),
    .CNT_W   (32),
    .PRESC_W (8)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .wen_i            (wen_i),
    .waddr_i          (waddr_i),
    .wdata_i          (wdata_i),
    .raddr_i          (raddr_i),
    .rdata_o          (rdata_o),
    .timer_irq_o      (timer_irq_o),
    .timer_int_flag_o (timer_int_flag_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Each access uses exactly one rising edge and returns 1 time unit after it.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk_i);
    wen_i   = 1'b1;
    waddr_i = a;
    wdata_i = d;
    @(posedge clk_i);
    #1;
    wen_i = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk_i);
    raddr_i = a;
    @(posedge clk_i);
    #1;
    check(tag, rdata_o, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i   = 1'b1;
    wen_i   = 1'b0;
    waddr_i = '0;
    wdata_i = '0;
    raddr_i = '0;
    #2;
    check("reset rdata", rdata_o, 32'h0);
    check("reset irq", {28'h0, timer_irq_o}, 32'h0);
    check("reset flag", {31'h0, timer_int_flag_o}, 32'h0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // ch0 one-shot: PEND 5 edges after the enabling write
    wr(32'h0C, 32'h0);
    wr(32'h08, 32'h4);
    wr(32'h00, 32'h3);
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      check("oneshot irq0", {28'h0, timer_irq_o}, (i == 5) ? 32'h1 : 32'h0);
    end
    rd_chk("oneshot ctrl", 32'h00, 32'h6);
    rd_chk("oneshot count", 32'h04, 32'h0);
    wr(32'h00, 32'h4);
    rd_chk("ch0 cleared", 32'h00, 32'h0);

    // ch1 periodic, period (3+1)*(2+1)=12; W1C with EN=1 must not restart
    wr(32'h1C, 32'h2);
    wr(32'h18, 32'h3);
    wr(32'h10, 32'hB);
    tick(11);
    check("periodic irq1 early", {28'h0, timer_irq_o}, 32'h0);
    tick(1);
    check("periodic irq1 first", {28'h0, timer_irq_o}, 32'h2);
    wr(32'h10, 32'hD);
    check("w1c irq1", {28'h0, timer_irq_o}, 32'h0);
    check("w1c flag", {31'h0, timer_int_flag_o}, 32'h0);
    tick(9);
    rd_chk("periodic status pre", 32'h80, 32'h0);
    rd_chk("periodic status second", 32'h80, 32'h2);
    wr(32'h10, 32'h4);

    // ch2: lowering CMP under a running COUNT matches on the next tick
    wr(32'h2C, 32'h0);
    wr(32'h28, 32'd100);
    wr(32'h20, 32'h9);
    tick(9);
    rd_chk("ch2 count 10", 32'h24, 32'd10);
    wr(32'h28, 32'd5);
    rd_chk("ch2 count after cmp", 32'h24, 32'h0);
    rd_chk("ch2 ctrl after cmp", 32'h20, 32'hD);
    rd_chk("ch2 status", 32'h80, 32'h4);
    wr(32'h20, 32'hD);
    rd_chk("ch2 w1c off-match", 32'h80, 32'h0);
    tick(1);
    wr(32'h20, 32'hD);                  // lands on the COUNT=5 match edge
    rd_chk("ch2 set beats w1c", 32'h20, 32'hD);
    rd_chk("ch2 status set", 32'h80, 32'h4);
    wr(32'h20, 32'h4);

    // ch0/ch3: one write port, so ch3 starts one edge later with CMP one lower
    wr(32'h0C, 32'h0);
    wr(32'h08, 32'h4);
    wr(32'h3C, 32'h0);
    wr(32'h38, 32'h3);
    wr(32'h00, 32'h3);
    wr(32'h30, 32'h3);
    tick(3);
    check("dual irq early", {28'h0, timer_irq_o}, 32'h0);
    tick(1);
    check("dual irq same edge", {28'h0, timer_irq_o}, 32'h9);
    check("dual flag", {31'h0, timer_int_flag_o}, 32'h1);
    rd_chk("dual status", 32'h80, 32'h9);
    foreach (bad_addr[i]) wr(bad_addr[i], 32'hFFFF_FFFF);
    rd_chk("ignored ch0 ctrl", 32'h00, 32'h6);
    rd_chk("ignored ch0 cmp", 32'h08, 32'h4);
    rd_chk("ignored ch0 presc", 32'h0C, 32'h0);
    rd_chk("ignored ch3 ctrl", 32'h30, 32'h6);
    rd_chk("ignored ch3 cmp", 32'h38, 32'h3);
    rd_chk("ignored ch1 ctrl", 32'h10, 32'h0);
    rd_chk("ignored status", 32'h80, 32'h9);
    rd_chk("unmapped read", 32'h44, 32'h0);

    // asynchronous reset mid-count with interrupts pending
    wr(32'h10, 32'hB);
    tick(5);
    @(negedge clk_i);
    raddr_i = 32'h08;
    @(posedge clk_i);
    #3;
    check("pre-rst rdata", rdata_o, 32'h4);
    check("pre-rst irq", {28'h0, timer_irq_o}, 32'h9);
    #1;
    rst_i = 1'b1;
    #1;
    check("async rst rdata", rdata_o, 32'h0);
    check("async rst irq", {28'h0, timer_irq_o}, 32'h0);
    check("async rst flag", {31'h0, timer_int_flag_o}, 32'h0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int o = 0; o < 16; o += 4) begin
        rd_chk("post-rst reg", 32'(c * 16 + o), 32'h0);
      end
    end
    rd_chk("post-rst status", 32'h80, 32'h0);
    tick(20);
    check("post-rst irq idle", {28'h0, timer_irq_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_timer_multi
`default_nettype wire
